// File: rtl/fifo_ram_ctrl.sv
// FIFO controller sequencing a combinational dual-port RAM: port 0 writes, port 1 reads.
// Provides a valid/ready push side and a first-word-fall-through valid/ready pop side.
module fifo_ram_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] address_0,
  output logic                  chip_enable_0,
  output logic                  write_read_0,
  output logic [DATA_WIDTH-1:0] data_0,
  output logic [ADDR_WIDTH-1:0] address_1,
  output logic                  chip_enable_1,
  output logic                  write_read_1,
  input  logic [DATA_WIDTH-1:0] data_1
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

  // Handshakes: a push happens on an edge where wr_valid && wr_ready; a pop happens
  // on an edge where rd_valid && rd_ready. Neither ready depends on its own valid.

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   committed_q, committed_d;
  logic                  ce0_q, ce0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
  logic [DATA_WIDTH-1:0] data0_q, data0_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic [ADDR_WIDTH:0]   ram_occ;
  logic                  wr_ready_int;
  logic                  push;
  logic                  fetch;
  logic                  pop;

  always_comb begin
    // RAM occupancy includes the word still in the write stage, so wr_ready
    // never relies on a same-cycle pop.
    ram_occ      = committed_q + {{ADDR_WIDTH{1'b0}}, ce0_q};
    wr_ready_int = (ram_occ != DEPTH_C);
    push         = wr_valid && wr_ready_int && !flush;
    fetch        = (committed_q != '0) && (!rd_valid_q || rd_ready) && !flush;
    pop          = rd_valid_q && rd_ready;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    committed_d = committed_q;
    ce0_d       = 1'b0;
    addr0_d     = addr0_q;
    data0_d     = data0_q;
    rd_valid_d  = rd_valid_q;
    rd_data_d   = rd_data_q;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      committed_d = '0;
      addr0_d     = '0;
      data0_d     = '0;
      rd_valid_d  = 1'b0;
      rd_data_d   = '0;
    end else begin
      if (push) begin
        ce0_d    = 1'b1;
        addr0_d  = wr_ptr_q;
        data0_d  = wr_data;
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end
      // Retire the write-stage word and consume a committed word in one step.
      committed_d = committed_q + {{ADDR_WIDTH{1'b0}}, ce0_q}
                                - {{ADDR_WIDTH{1'b0}}, fetch};
      if (fetch) begin
        rd_data_d  = data_1;
        rd_valid_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
      end else if (pop) begin
        rd_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      committed_q <= '0;
      ce0_q       <= 1'b0;
      addr0_q     <= '0;
      data0_q     <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      committed_q <= committed_d;
      ce0_q       <= ce0_d;
      addr0_q     <= addr0_d;
      data0_q     <= data0_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign wr_ready      = wr_ready_int;
  assign full          = !wr_ready_int;
  assign count         = ram_occ + {{ADDR_WIDTH{1'b0}}, rd_valid_q};
  assign empty         = (count == '0);
  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign address_0     = addr0_q;
  assign chip_enable_0 = ce0_q;
  assign write_read_0  = 1'b1;
  assign data_0        = data0_q;
  // The read strobe drops in every non-fetch cycle so the RAM re-evaluates next time.
  assign address_1     = rd_ptr_q;
  assign chip_enable_1 = fetch;
  assign write_read_1  = 1'b0;

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Bench for fifo_ram_ctrl with a 4-deep RAM: directed scenarios plus random traffic,
// checked against a queue-based model of the FIFO stages and an ordering scoreboard.
module tb_fifo_ram_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;
  logic          full, empty;
  logic [AW-1:0] address_0, address_1;
  logic          chip_enable_0, chip_enable_1;
  logic          write_read_0, write_read_1;
  logic [DW-1:0] data_0, data_1;

  // clock/reset block
  always #5 clk = ~clk;

  fifo_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .full(full), .empty(empty),
    .address_0(address_0), .chip_enable_0(chip_enable_0),
    .write_read_0(write_read_0), .data_0(data_0),
    .address_1(address_1), .chip_enable_1(chip_enable_1),
    .write_read_1(write_read_1), .data_1(data_1)
  );

  // Combinational dual-port RAM: port 0 writes at the edge, port 1 reads combinationally.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (chip_enable_0 && write_read_0) mem[address_0] <= data_0;
  end
  assign data_1 = chip_enable_1 ? mem[address_1] : '0;

  // Reference model: words move write stage -> RAM queue -> output register.
  logic [DW-1:0] ram_q[$];
  logic [DW-1:0] exp_q[$];
  logic          pend_valid;
  logic [DW-1:0] pend_data;
  int            pend_addr;
  logic          out_valid;
  logic [DW-1:0] out_data;
  int            m_wr_ptr, m_rd_ptr;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    ram_q.delete();
    exp_q.delete();
    pend_valid = 1'b0;
    pend_data  = '0;
    pend_addr  = 0;
    out_valid  = 1'b0;
    out_data   = '0;
    m_wr_ptr   = 0;
    m_rd_ptr   = 0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_count"}, count, 0);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_full"}, full, 0);
    check({tag, "_wr_ready"}, wr_ready, 1);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_ce0"}, chip_enable_0, 0);
    check({tag, "_addr0"}, address_0, 0);
    check({tag, "_data0"}, data_0, 0);
    check({tag, "_ce1"}, chip_enable_1, 0);
    check({tag, "_wr0"}, write_read_0, 1);
    check({tag, "_wr1"}, write_read_1, 0);
  endtask

  // Asynchronous reset applied between edges; all outputs must clear immediately.
  task automatic do_reset();
    @(negedge clk);
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    flush    = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("reset");
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("reset_no_write", chip_enable_0, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Driver: one clock cycle with the given inputs; checks outputs mid-cycle, then
  // advances the model at the edge. Returns whether the push was accepted.
  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr,
                      input logic fl, output logic accepted);
    int   occ;
    logic exp_fetch;
    @(negedge clk);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    #1;
    occ       = ram_q.size() + int'(pend_valid);
    exp_fetch = (ram_q.size() > 0) && (!out_valid || rr) && !fl;
    check("wr_ready", wr_ready, occ != DEPTH);
    check("full", full, occ == DEPTH);
    check("count", count, occ + int'(out_valid));
    check("empty", empty, (occ + int'(out_valid)) == 0);
    check("rd_valid", rd_valid, out_valid);
    if (out_valid) check("rd_data", rd_data, out_data);
    check("ce0", chip_enable_0, pend_valid);
    if (pend_valid) begin
      check("addr0", address_0, pend_addr);
      check("data0", data_0, pend_data);
    end
    check("ce1", chip_enable_1, exp_fetch);
    if (exp_fetch) check("addr1", address_1, m_rd_ptr);
    if (rd_valid && rr && !fl) begin
      if (exp_q.size() == 0) check("sb_unexpected_pop", 1, 0);
      else check("sb_order", rd_data, exp_q.pop_front());
    end
    accepted = wv && (occ != DEPTH) && !fl;
    @(posedge clk);
    if (fl) begin
      model_clear();
      accepted = 1'b0;
    end else begin
      if (exp_fetch) begin
        out_data  = ram_q.pop_front();
        out_valid = 1'b1;
        m_rd_ptr  = (m_rd_ptr + 1) % DEPTH;
      end else if (out_valid && rr) begin
        out_valid = 1'b0;
      end
      if (pend_valid) ram_q.push_back(pend_data);
      pend_valid = accepted;
      if (accepted) begin
        pend_data = wd;
        pend_addr = m_wr_ptr;
        m_wr_ptr  = (m_wr_ptr + 1) % DEPTH;
        exp_q.push_back(wd);
      end
    end
  endtask

  task automatic idle(input int n, input logic rr);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, rr, 1'b0, acc);
  endtask

  initial begin
    logic acc;
    int   sent;
    int   guard;
    model_clear();
    do_reset();
    idle(2, 1'b0);

    // Single push, then hold the consumer off.
    step(1'b1, 8'hA5, 1'b0, 1'b0, acc);
    #1;
    check("single_ce0", chip_enable_0, 1);
    check("single_addr0", address_0, 0);
    check("single_count1", count, 1);
    idle(2, 1'b0);
    #1;
    check("single_rd_valid", rd_valid, 1);
    check("single_rd_data", rd_data, 8'hA5);
    idle(2, 1'b1);

    // Fill: RAM plus output register hold DEPTH+1 words.
    for (int i = 1; i <= 6; i++) step(1'b1, DW'(i), 1'b0, 1'b0, acc);
    idle(2, 1'b0);
    #1;
    check("fill_count", count, DEPTH + 1);
    check("fill_full", full, 1);
    step(1'b1, 8'd6, 1'b1, 1'b0, acc);
    step(1'b1, 8'd6, 1'b1, 1'b0, acc);
    idle(10, 1'b1);

    // Streaming 0..99 with a consumer that is always ready.
    sent = 0;
    guard = 0;
    while (sent < 100 && guard < 1000) begin
      step(1'b1, DW'(sent), 1'b1, 1'b0, acc);
      if (acc) sent++;
      guard++;
    end
    check("stream_timeout", guard < 1000, 1);
    idle(6, 1'b1);
    check("stream_drained", exp_q.size(), 0);

    // Simultaneous push and pop holding count at 3.
    for (int i = 0; i < 3; i++) step(1'b1, DW'(8'h40 + i), 1'b0, 1'b0, acc);
    idle(3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, DW'(8'h50 + i), 1'b1, 1'b0, acc);
      #1;
      check("pp_count", count, 3);
    end
    idle(6, 1'b1);

    // Reset mid-stream, then a fresh word from address 0.
    for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h60 + i), 1'b1, 1'b0, acc);
    do_reset();
    step(1'b1, 8'h3C, 1'b0, 1'b0, acc);
    #1;
    check("post_reset_addr0", address_0, 0);
    idle(3, 1'b0);
    #1;
    check("post_reset_rd", rd_data, 8'h3C);
    idle(2, 1'b1);

    // Flush at count 4 with a concurrent push that must be dropped.
    for (int i = 0; i < 4; i++) step(1'b1, DW'(8'h70 + i), 1'b0, 1'b0, acc);
    idle(2, 1'b0);
    check("flush_pre_count", count, 4);
    step(1'b1, 8'h77, 1'b0, 1'b1, acc);
    #1;
    check_cleared("flush");
    step(1'b1, 8'h5A, 1'b0, 1'b0, acc);
    #1;
    check("post_flush_addr0", address_0, 0);
    idle(3, 1'b0);
    #1;
    check("post_flush_rd", rd_data, 8'h5A);
    idle(2, 1'b1);

    // Random traffic with rare flushes.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 2) != 0), DW'($urandom_range(0, 255)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 59) == 0), acc);
    end
    idle(8, 1'b1);
    check("final_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
